// File: rtl/nbr_eval_ctrl.sv
// Challenge sequencer and response collector for the NBR32 bistable-ring PUF.
// Each challenge is evaluated NEVAL times, majority-voted into RESP, and advanced by a Galois LFSR.
module nbr_eval_ctrl #(
    parameter int unsigned NBITS         = 32,
    parameter int unsigned NEVAL         = 5,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [31:0]      SEED,
    output logic             BUSY,
    output logic             DONE,
    output logic [NBITS-1:0] RESP,
    output logic [15:0]      FLIPS,
    output logic             RING_RESET,
    output logic [31:0]      RING_C,
    input  logic             RING_OUT
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned EVAL_W = 4;
    localparam int unsigned IDX_W  = 5;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SETTLE,
        SAMPLE,
        NEXT,
        FIN
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [EVAL_W-1:0]   eval_cnt;
    logic [EVAL_W-1:0]   ones;
    logic [IDX_W-1:0]    bit_idx;
    logic                sync_q1;
    logic                sync_q2;
    logic                vote_c;
    logic                split_c;

    function automatic logic [31:0] lfsr_step(input logic [31:0] c);
        return (c >> 1) ^ (c[0] ? LFSR_MASK : 32'h0000_0000);
    endfunction

    // Majority and non-unanimity of the votes collected for the current challenge
    assign vote_c  = (ones > EVAL_W'(NEVAL / 2));
    assign split_c = (ones != '0) && (ones != EVAL_W'(NEVAL));

    // Two-flop synchronizer on the asynchronous ring output
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= RING_OUT;
            sync_q2 <= sync_q1;
        end
    end

    // Sequencer: ring reset, settle, sample, vote, advance challenge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            RESP       <= '0;
            FLIPS      <= '0;
            RING_RESET <= 1'b1;
            RING_C     <= '0;
            cnt        <= '0;
            eval_cnt   <= '0;
            ones       <= '0;
            bit_idx    <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    RING_RESET <= 1'b1;
                    BUSY       <= 1'b0;
                    if (START) begin
                        RING_C   <= (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;
                        RESP     <= '0;
                        FLIPS    <= '0;
                        eval_cnt <= '0;
                        ones     <= '0;
                        bit_idx  <= '0;
                        cnt      <= '0;
                        BUSY     <= 1'b1;
                        state    <= RST;
                    end
                end
                RST: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        cnt        <= '0;
                        RING_RESET <= 1'b0;
                        state      <= SETTLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    ones       <= ones + {{(EVAL_W-1){1'b0}}, sync_q2};
                    RING_RESET <= 1'b1;
                    if (eval_cnt < EVAL_W'(NEVAL - 1)) begin
                        eval_cnt <= eval_cnt + EVAL_W'(1);
                        state    <= RST;
                    end else begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    for (int unsigned i = 0; i < NBITS; i++) begin
                        if (bit_idx == IDX_W'(i)) begin
                            RESP[i] <= vote_c;
                        end
                    end
                    if (split_c && (FLIPS != 16'hFFFF)) begin
                        FLIPS <= FLIPS + 16'd1;
                    end
                    // Challenge moves while the ring is still held in reset
                    RING_C   <= lfsr_step(RING_C);
                    ones     <= '0;
                    eval_cnt <= '0;
                    if (bit_idx == IDX_W'(NBITS - 1)) begin
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        state   <= RST;
                    end
                end
                FIN: begin
                    RING_RESET <= 1'b1;
                    BUSY       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
